// File: rtl/render_pkg.sv
// Shared render fixed-point types, scan FSM states and the fixed-point floor helper.
package render_pkg;
  localparam int INTEGER   = 10;
  localparam int DECIMAL   = 7;
  localparam int PRECISION = 1 + INTEGER + DECIMAL;

  typedef logic signed [PRECISION-1:0] fix_t;
  typedef logic [INTEGER-1:0]          pix_t;
  typedef logic signed [INTEGER:0]     ipart_t;

  typedef enum logic [1:0] {IDLE, SETUP, CLAMP, SCAN} scan_state_t;

  // Arithmetic shift floors toward -inf, so -0.5 lands on pixel -1.
  function automatic ipart_t floor_fix(fix_t v);
    fix_t s;
    s = v >>> DECIMAL;
    return ipart_t'(s[INTEGER:0]);
  endfunction
endpackage

// File: rtl/tri_bbox.sv
// Combinational screen bounding box of a triangle: floor, min/max, clamp and empty flag.
module tri_bbox
  import render_pkg::*;
#(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600
) (
  input  logic [PRECISION-1:0] x1,
  input  logic [PRECISION-1:0] y1,
  input  logic [PRECISION-1:0] x2,
  input  logic [PRECISION-1:0] y2,
  input  logic [PRECISION-1:0] x3,
  input  logic [PRECISION-1:0] y3,
  output logic [INTEGER-1:0]   xmin,
  output logic [INTEGER-1:0]   xmax,
  output logic [INTEGER-1:0]   ymin,
  output logic [INTEGER-1:0]   ymax,
  output logic                 empty
);
  localparam ipart_t XLIM = ipart_t'(WIDTH - 1);
  localparam ipart_t YLIM = ipart_t'(HEIGHT - 1);

  ipart_t lo_x, hi_x, lo_y, hi_y;

  function automatic ipart_t min3(ipart_t a, ipart_t b, ipart_t c);
    ipart_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic ipart_t max3(ipart_t a, ipart_t b, ipart_t c);
    ipart_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic pix_t clamp(ipart_t v, ipart_t lim);
    if (v[INTEGER]) return '0;
    if (v > lim) return lim[INTEGER-1:0];
    return v[INTEGER-1:0];
  endfunction

  assign lo_x = min3(floor_fix(x1), floor_fix(x2), floor_fix(x3));
  assign hi_x = max3(floor_fix(x1), floor_fix(x2), floor_fix(x3));
  assign lo_y = min3(floor_fix(y1), floor_fix(y2), floor_fix(y3));
  assign hi_y = max3(floor_fix(y1), floor_fix(y2), floor_fix(y3));

  assign xmin = clamp(lo_x, XLIM);
  assign xmax = clamp(hi_x, XLIM);
  assign ymin = clamp(lo_y, YLIM);
  assign ymax = clamp(hi_y, YLIM);

  // Emptiness is judged on the unclamped box; clamping would hide a fully off-screen triangle.
  assign empty = hi_x[INTEGER] | hi_y[INTEGER] | (lo_x > XLIM) | (lo_y > YLIM);
endmodule

// File: rtl/tri_scan_ctrl.sv
// Triangle scan sequencer: accepts a triangle, bounds it, walks its box row-major to the datapath.
// Optional back-face culling with saturating cull_cnt when TRI_SCAN_CULL_EN is defined.
module tri_scan_ctrl
  import render_pkg::*;
#(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [PRECISION-1:0] in_x1,
  input  logic [PRECISION-1:0] in_y1,
  input  logic [PRECISION-1:0] in_x2,
  input  logic [PRECISION-1:0] in_y2,
  input  logic [PRECISION-1:0] in_x3,
  input  logic [PRECISION-1:0] in_y3,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [INTEGER-1:0]   out_px,
  output logic [INTEGER-1:0]   out_py,
  output logic [PRECISION-1:0] out_x1,
  output logic [PRECISION-1:0] out_y1,
  output logic [PRECISION-1:0] out_x2,
  output logic [PRECISION-1:0] out_y2,
  output logic [PRECISION-1:0] out_x3,
  output logic [PRECISION-1:0] out_y3,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 busy
`ifdef TRI_SCAN_CULL_EN
  ,
  output logic [15:0]          cull_cnt
`endif
);
  scan_state_t state, state_nxt;
  pix_t px, py, xmin_q, xmax_q, ymin_q, ymax_q;
  pix_t bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic empty_q, bb_empty, cull_hit, at_end;

  tri_bbox #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_bbox (
    .x1(out_x1), .y1(out_y1), .x2(out_x2), .y2(out_y2), .x3(out_x3), .y3(out_y3),
    .xmin(bb_xmin), .xmax(bb_xmax), .ymin(bb_ymin), .ymax(bb_ymax), .empty(bb_empty)
  );

  assign in_rdy    = (state == IDLE);
  assign out_vld   = (state == SCAN);
  assign busy      = (state != IDLE);
  assign out_px    = px;
  assign out_py    = py;
  assign at_end    = (px == xmax_q) && (py == ymax_q);
  assign out_first = out_vld && (px == xmin_q) && (py == ymin_q);
  assign out_last  = out_vld && at_end;

`ifdef TRI_SCAN_CULL_EN
  localparam int AW = 2*PRECISION + 2;
  logic signed [PRECISION:0] dx21, dy31, dy21, dx31;
  logic signed [AW-1:0] area, area_q;

  assign dx21 = $signed({out_x2[PRECISION-1], out_x2}) - $signed({out_x1[PRECISION-1], out_x1});
  assign dy31 = $signed({out_y3[PRECISION-1], out_y3}) - $signed({out_y1[PRECISION-1], out_y1});
  assign dy21 = $signed({out_y2[PRECISION-1], out_y2}) - $signed({out_y1[PRECISION-1], out_y1});
  assign dx31 = $signed({out_x3[PRECISION-1], out_x3}) - $signed({out_x1[PRECISION-1], out_x1});
  assign area = AW'(dx21) * AW'(dy31) - AW'(dy21) * AW'(dx31);
  // Zero area (collinear) is culled together with clockwise winding.
  assign cull_hit = area_q[AW-1] | (area_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      area_q   <= '0;
      cull_cnt <= '0;
    end else begin
      if (state == SETUP) area_q <= area;
      if (state == CLAMP && cull_hit && cull_cnt != 16'hffff) cull_cnt <= cull_cnt + 16'd1;
    end
  end
`else
  assign cull_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_vld) state_nxt = SETUP;
      SETUP:   state_nxt = CLAMP;
      CLAMP:   state_nxt = (empty_q || cull_hit) ? IDLE : SCAN;
      SCAN:    if (out_rdy && at_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {out_x1, out_y1, out_x2, out_y2, out_x3, out_y3} <= '0;
      {xmin_q, xmax_q, ymin_q, ymax_q} <= '0;
      empty_q <= 1'b0;
      px      <= '0;
      py      <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_vld) begin
          out_x1 <= in_x1; out_y1 <= in_y1;
          out_x2 <= in_x2; out_y2 <= in_y2;
          out_x3 <= in_x3; out_y3 <= in_y3;
        end
        SETUP: begin
          xmin_q  <= bb_xmin;
          xmax_q  <= bb_xmax;
          ymin_q  <= bb_ymin;
          ymax_q  <= bb_ymax;
          empty_q <= bb_empty;
        end
        CLAMP: begin
          px <= xmin_q;
          py <= ymin_q;
        end
        SCAN: if (out_rdy) begin
          if (px < xmax_q) begin
            px <= px + 1'b1;
          end else if (py < ymax_q) begin
            px <= xmin_q;
            py <= py + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tri_scan_ctrl.sv
// Scoreboard bench for tri_scan_ctrl: directed cases plus random triangles against a box model.
module tb_tri_scan_ctrl;
  import render_pkg::*;

  localparam int W = 800;
  localparam int H = 600;

  logic clk = 1'b0, rst = 1'b1, in_vld = 1'b0, out_rdy = 1'b0;
  logic in_rdy, out_vld, out_first, out_last, busy;
  logic [PRECISION-1:0] in_x1 = '0, in_y1 = '0, in_x2 = '0, in_y2 = '0, in_x3 = '0, in_y3 = '0;
  logic [PRECISION-1:0] out_x1, out_y1, out_x2, out_y2, out_x3, out_y3;
  logic [INTEGER-1:0] out_px, out_py;
`ifdef TRI_SCAN_CULL_EN
  logic [15:0] cull_cnt;
  int exp_cull = 0;
`endif

  typedef struct {int px; int py; bit first; bit last; int x1; int y3;} pix_e;
  pix_e exp_q[$];

  int total = 0, bad = 0, hs_cnt = 0, cyc = 0, mode = 0;
  bit rdy_chk = 0, hold_chk = 0;
  pix_e held;

  tri_scan_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_x1(in_x1), .in_y1(in_y1), .in_x2(in_x2), .in_y2(in_y2), .in_x3(in_x3), .in_y3(in_y3),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_px(out_px), .out_py(out_py),
    .out_x1(out_x1), .out_y1(out_y1), .out_x2(out_x2), .out_y2(out_y2),
    .out_x3(out_x3), .out_y3(out_y3),
    .out_first(out_first), .out_last(out_last), .busy(busy)
`ifdef TRI_SCAN_CULL_EN
    , .cull_cnt(cull_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // out_rdy patterns: 0 always ready, 1 the 1,0,0 repeat, 2 random
  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    case (mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = (cyc % 3 == 0);
      default: out_rdy = 1'($urandom_range(1));
    endcase
  end

  function automatic int fl(int r);
    return (r >= 0) ? r / 128 : -((-r + 127) / 128);
  endfunction

  function automatic int mn(int a, int b); return a < b ? a : b; endfunction
  function automatic int mx(int a, int b); return a > b ? a : b; endfunction

  task automatic model(input int v[6], output int n);
    int x0, x1, y0, y1;
    pix_e e;
    n = 0;
`ifdef TRI_SCAN_CULL_EN
    begin
      longint area;
      area = longint'(v[2] - v[0]) * longint'(v[5] - v[1]) - longint'(v[3] - v[1]) * longint'(v[4] - v[0]);
      if (area <= 0) begin
        if (exp_cull < 65535) exp_cull++;
        return;
      end
    end
`endif
    x0 = mn(fl(v[0]), mn(fl(v[2]), fl(v[4])));
    x1 = mx(fl(v[0]), mx(fl(v[2]), fl(v[4])));
    y0 = mn(fl(v[1]), mn(fl(v[3]), fl(v[5])));
    y1 = mx(fl(v[1]), mx(fl(v[3]), fl(v[5])));
    if (x1 < 0 || y1 < 0 || x0 > W-1 || y0 > H-1) return;
    x0 = mx(x0, 0); y0 = mx(y0, 0); x1 = mn(x1, W-1); y1 = mn(y1, H-1);
    n = (x1 - x0 + 1) * (y1 - y0 + 1);
    for (int k = 0; k < n; k++) begin
      e.px = x0 + k % (x1 - x0 + 1);
      e.py = y0 + k / (x1 - x0 + 1);
      e.first = (k == 0);
      e.last = (k == n - 1);
      e.x1 = v[0];
      e.y3 = v[5];
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rdy_chk = 0;
      hold_chk = 0;
    end else begin
      if (rdy_chk) begin
        chk("in_rdy_after_last", in_rdy, 1);
        rdy_chk = 0;
      end
      if (hold_chk) begin
        chk("hold_vld", out_vld, 1);
        chk("hold_px", out_px, held.px);
        chk("hold_py", out_py, held.py);
        chk("hold_first", out_first, held.first);
        chk("hold_last", out_last, held.last);
        hold_chk = 0;
      end
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel_count", 1, 0);
        end else begin
          held = exp_q[0];
          held.px = int'(out_px); held.py = int'(out_py);
          held.first = out_first; held.last = out_last;
          if (out_rdy) begin
            pix_e e;
            e = exp_q.pop_front();
            chk("px", out_px, e.px);
            chk("py", out_py, e.py);
            chk("first", out_first, e.first);
            chk("last", out_last, e.last);
            chk("vert_x1", $signed(out_x1), e.x1);
            chk("vert_y3", $signed(out_y3), e.y3);
            hs_cnt++;
            if (e.last) rdy_chk = 1;
          end else begin
            hold_chk = 1;
          end
        end
      end
    end
  end

  task automatic send(input int v[6], input bit lat);
    int n;
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_rdy) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("in_rdy_timeout", 0, 1);
      return;
    end
    in_x1 = PRECISION'(v[0]); in_y1 = PRECISION'(v[1]);
    in_x2 = PRECISION'(v[2]); in_y2 = PRECISION'(v[3]);
    in_x3 = PRECISION'(v[4]); in_y3 = PRECISION'(v[5]);
    in_vld = 1'b1;
    @(posedge clk);
    model(v, n);
    #1;
    in_x1 = PRECISION'($urandom); in_y3 = PRECISION'($urandom);
    @(negedge clk);
    if (lat) chk("lat_setup_vld", out_vld, 0);
    @(posedge clk);
    #1 in_vld = 1'b0;
    @(negedge clk);
    if (lat) chk("lat_clamp_vld", out_vld, 0);
    @(negedge clk);
    if (lat) begin
      chk("lat_t3_vld", out_vld, n != 0);
      chk("lat_t3_in_rdy", in_rdy, n == 0);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin ok = 1; break; end
    end
    chk("drain_done", ok, 1);
  endtask

  int tri_b[6]   = '{256, 256, 640, 256, 256, 512};
  int tri_off[6] = '{-1280, 256, -1280, 512, -1280, 256};
  int tri_clp[6] = '{101120, 76160, 115200, 76160, 101120, 89600};
  int tri_sw[6]  = '{256, 256, 256, 512, 640, 256};
  int tri_r[6];

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    chk("rst_px", out_px, 0);
    chk("rst_py", out_py, 0);
    chk("rst_x1", out_x1, 0);
    chk("rst_y3", out_y3, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_rdy", in_rdy, 1);

    mode = 0; send(tri_b, 1);   wait_idle();
    send(tri_off, 1);           wait_idle();
    send(tri_clp, 1);           wait_idle();
    mode = 1; send(tri_b, 0);   wait_idle();
`ifdef TRI_SCAN_CULL_EN
    mode = 0; send(tri_sw, 1);  wait_idle();
`endif

    mode = 0;
    begin
      int base;
      base = hs_cnt;
      send(tri_b, 0);
      for (int i = 0; i < 100 && hs_cnt < base + 4; i++) @(posedge clk);
      chk("rst_mid_pixels_before", hs_cnt - base, 4);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("rst_mid_out_vld", out_vld, 0);
      chk("rst_mid_busy", busy, 0);
      send(tri_b, 1);
      wait_idle();
    end

    mode = 2;
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 3; k++) begin
        int cx, cy;
        cx = int'($urandom_range(860)) - 30 + int'($urandom_range(24)) - 12;
        cy = int'($urandom_range(660)) - 30 + int'($urandom_range(24)) - 12;
        tri_r[2*k]   = cx * 128 + int'($urandom_range(127));
        tri_r[2*k+1] = cy * 128 + int'($urandom_range(127));
      end
      // Keep the box small so the run stays short: pull v2 and v3 near v1.
      for (int k = 1; k < 3; k++) begin
        tri_r[2*k]   = tri_r[0] + (int'($urandom_range(3000)) - 1500);
        tri_r[2*k+1] = tri_r[1] + (int'($urandom_range(3000)) - 1500);
      end
      send(tri_r, t[0]);
      wait_idle();
    end

`ifdef TRI_SCAN_CULL_EN
    chk("cull_cnt", cull_cnt, exp_cull);
`endif
    chk("queue_empty_end", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tri_scan_ctrl.md
Name: tri_scan_ctrl

Overview:
- Triangle scan sequencer in front of the edge-function render datapath.
- Accepts one triangle at a time (fixed-point vertices) via valid/ready, then computes and clamps its screen bounding box.
- Walks every pixel of the bounding box in row-major order, presenting pixel coordinates plus the held vertices to the datapath with valid/ready backpressure.
- Replaces the free-running full-screen pixel counter.

Parameters:
- WIDTH, 800, screen width in pixels.
- HEIGHT, 600, screen height in pixels.
- INTEGER, 10, integer bits of vertex fixed-point.
- DECIMAL, 7, fractional bits of vertex fixed-point.
- PRECISION, 1+INTEGER+DECIMAL, signed vertex word width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  triangle valid.
- in_rdy  out  1  controller can accept a triangle.
- in_x1,in_y1,in_x2,in_y2,in_x3,in_y3  in  PRECISION each  signed fixed-point vertices.
- out_vld  out  1  pixel request valid.
- out_rdy  in  1  datapath accepts pixel.
- out_px  out  INTEGER  pixel x (integer).
- out_py  out  INTEGER  pixel y (integer).
- out_x1..out_y3  out  PRECISION each  latched vertices, stable from accept until return to IDLE.
- out_first  out  1  current pixel is the first of the triangle.
- out_last  out  1  current pixel is the last of the triangle.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - State IDLE.
  - out_vld, out_first, out_last, busy = 0.
  - out_px, out_py, out_x* = 0.
  - in_rdy = (state==IDLE), so it is 1 in the cycle after reset is released.
- Reset mid-operation: the triangle is abandoned, no further pixels are emitted, and there is no partial flush.
- FSM: IDLE -> SETUP -> CLAMP -> SCAN -> IDLE.
- IDLE: in_rdy=1. On in_vld&in_rdy (edge T), latch the six vertices and go to SETUP.
- SETUP (T+1):
  - Integer floor of each coordinate: arithmetic shift >>> DECIMAL.
  - xmin/xmax/ymin/ymax = min/max of the three floored values, signed (INTEGER+1 bits).
- CLAMP (T+2):
  - Clamp x to [0, WIDTH-1] and y to [0, HEIGHT-1].
  - If the unclamped xmax<0, ymax<0, xmin>WIDTH-1 or ymin>HEIGHT-1, the box is empty: go to IDLE with no output.
  - Otherwise load px=xmin, py=ymin and go to SCAN.
- SCAN:
  - out_vld=1; the first request appears in cycle T+3.
  - On out_vld&out_rdy:
    - if px<xmax, px++;
    - else if py<ymax, px=xmin and py++;
    - else go to IDLE, with out_vld=0 in the next cycle.
  - With out_vld high and out_rdy low, all outputs hold stable.
  - out_first = (px==xmin && py==ymin). out_last = (px==xmax && py==ymax).
  - A degenerate 1x1 box gives exactly one pixel with first and last both 1.
- Throughput: one pixel per cycle under continuous out_rdy. Total pixels emitted = (xmax-xmin+1)*(ymax-ymin+1).
- in_rdy is 0 in SETUP, CLAMP and SCAN. in_vld during those states is ignored (not latched).
- The next triangle can be accepted in the first IDLE cycle after the last handshake, so the per-triangle overhead is 3 cycles.

Optional Feature:
- Macro: TRI_SCAN_CULL_EN.
- Defined:
  - SETUP also computes area = (x2-x1)*(y3-y1) - (y2-y1)*(x3-x1), full 2*PRECISION+2-bit signed product, no shift.
  - If area<=0 in CLAMP, go to IDLE with no pixels and increment a 16-bit saturating output port cull_cnt (reset 0).
- Undefined: no area computation, every triangle is scanned, and cull_cnt does not exist.

Decomposition:
- Shared package render_pkg holds:
  - Constants INTEGER, DECIMAL, PRECISION.
  - Typedef fix_t (signed PRECISION).
  - Typedef pix_t (INTEGER bits).
  - Enum scan_state_t {IDLE, SETUP, CLAMP, SCAN}.
- One sub-module, tri_bbox: combinational min/max/floor/clamp plus the empty flag, instantiated once.
- The FSM and counters stay in tri_scan_ctrl.

Test Plan:
- Basic scan: vertices (2,2),(5,2),(2,4) as raw 256,256,640,256,256,512 with out_rdy=1.
  - Expect 12 pixels, first (2,2) with out_first=1, last (5,4) with out_last=1, first out_vld at T+3.
  - in_rdy returns high in the cycle after the last handshake.
- Off-screen: all x = -10.0 (raw -1280).
  - Expect zero out_vld and in_rdy=1 at T+3.
- Clamp: vertices (790,595),(900,595),(790,700).
  - Expect x 790..799 and y 595..599: 50 pixels, last (799,599).
- Backpressure: basic triangle with out_rdy toggling 1,0,0,1,...
  - Expect the pixel sequence identical to the basic case, outputs stable while out_rdy=0, and no pixel duplicated or skipped.
- Reset mid-scan: assert rst on the 5th pixel.
  - Expect out_vld=0 and busy=0 the next cycle, then a new triangle scans correctly.
- Cull (TRI_SCAN_CULL_EN): basic triangle with v2 and v3 swapped (area -6).
  - Expect no pixels and cull_cnt=1. The original order is scanned normally.
